// File: rtl/zcu102_mmcm_phase_ctrl.sv
// Dynamic fine phase-shift controller for the board-clock MMCM: walks PSEN/PSDONE handshakes
// toward a signed target, tracks the absolute position and watches MMCM lock.
module zcu102_mmcm_phase_ctrl #(
   parameter int unsigned PS_WIDTH    = 16,
   parameter int unsigned TIMEOUT     = 1023,  // >= 16
   parameter int unsigned LOCK_STABLE = 64     // >= 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mmcm_locked,
   input  logic [PS_WIDTH-1:0] target_phase,
   input  logic                target_valid,
   output logic                target_ready,
   output logic                psen,
   output logic                psincdec,
   input  logic                psdone,
   output logic [PS_WIDTH-1:0] current_phase,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic                lock_lost
);

   localparam int unsigned LW = $clog2(LOCK_STABLE + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] LockLast  = LW'(LOCK_STABLE - 1);
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StIdle     = 2'd1,
      StStep     = 2'd2,
      StWaitDone = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [LW-1:0]              lock_cnt_q, lock_cnt_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic signed [PS_WIDTH-1:0] tgt_q, tgt_d;
   logic signed [PS_WIDTH-1:0] phase_q, phase_d;
   logic signed [PS_WIDTH-1:0] phase_step;
   logic                       ready_q, ready_d;
   logic                       psen_q, psen_d;
   logic                       psinc_q, psinc_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       terr_q, terr_d;
   logic                       llost_q, llost_d;
   logic                       accept;

   assign phase_step = psinc_q ? phase_q + PS_WIDTH'(1) : phase_q - PS_WIDTH'(1);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      timer_d    = timer_q;
      tgt_d      = tgt_q;
      phase_d    = phase_q;
      psinc_d    = psinc_q;
      done_d     = 1'b0;
      terr_d     = terr_q;
      llost_d    = llost_q;
      accept     = 1'b0;

      unique case (state_q)
         StWaitLock: begin
            if (!mmcm_locked) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LockLast) begin
               lock_cnt_d = '0;
               state_d    = StIdle;
            end else begin
               lock_cnt_d = lock_cnt_q + LW'(1);
            end
         end
         StIdle: begin
            // ready_q is low in the done cycle, so this also enforces the gap between commands
            if (target_valid && ready_q) begin
               accept  = 1'b1;
               tgt_d   = $signed(target_phase);
               terr_d  = 1'b0;
               llost_d = 1'b0;
               if ($signed(target_phase) == phase_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StStep;
               end
            end
         end
         StStep: begin
            // The psen cycle itself counts toward the psdone timeout.
            timer_d = TW'(1);
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (psdone) begin
               phase_d = phase_step;
               if (phase_step == tgt_q) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StStep;
               end
            end else if (timer_q == TimerLast) begin
               terr_d  = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = StWaitLock;
      endcase

      // A relock discards the MMCM shift; this outranks psdone, timeout and accept.
      if (state_q != StWaitLock && !mmcm_locked) begin
         state_d    = StWaitLock;
         lock_cnt_d = '0;
         tgt_d      = tgt_q;
         phase_d    = '0;
         terr_d     = terr_q;
         llost_d    = 1'b1;
         done_d     = (state_q == StStep) || (state_q == StWaitDone);
      end

      if (state_d == StStep) begin
         psinc_d = tgt_d > phase_d;
      end

      ready_d = (state_d == StIdle) && !done_d;
      busy_d  = (state_d != StIdle);
      psen_d  = (state_d == StStep);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StWaitLock;
         lock_cnt_q <= '0;
         timer_q    <= '0;
         tgt_q      <= '0;
         phase_q    <= '0;
         ready_q    <= 1'b0;
         psen_q     <= 1'b0;
         psinc_q    <= 1'b0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
         llost_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         timer_q    <= timer_d;
         tgt_q      <= tgt_d;
         phase_q    <= phase_d;
         ready_q    <= ready_d;
         psen_q     <= psen_d;
         psinc_q    <= psinc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         terr_q     <= terr_d;
         llost_q    <= llost_d;
      end
   end

   assign target_ready  = ready_q;
   assign psen          = psen_q;
   assign psincdec      = psinc_q;
   assign current_phase = phase_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout_err   = terr_q;
   assign lock_lost     = llost_q;

endmodule

// File: tb/tb_zcu102_mmcm_phase_ctrl.sv
// Directed self-checking bench for zcu102_mmcm_phase_ctrl with a fixed-latency PSDONE model.
module tb_zcu102_mmcm_phase_ctrl;

   localparam int unsigned PS_WIDTH = 16;
   localparam int PsLat = 12;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                mmcm_locked = 1'b1;
   logic [PS_WIDTH-1:0] target_phase = '0;
   logic                target_valid = 1'b0;
   logic                target_ready;
   logic                psen;
   logic                psincdec;
   logic                psdone;
   logic [PS_WIDTH-1:0] current_phase;
   logic                busy;
   logic                done;
   logic                timeout_err;
   logic                lock_lost;

   logic psdone_m = 1'b0;
   logic psdone_f = 1'b0;
   bit   ps_en = 1'b1;
   int   ps_cnt = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   assign psdone = psdone_m | psdone_f;

   always #5 clk = ~clk;

   zcu102_mmcm_phase_ctrl #(
      .PS_WIDTH    (PS_WIDTH),
      .TIMEOUT     (1023),
      .LOCK_STABLE (64)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mmcm_locked   (mmcm_locked),
      .target_phase  (target_phase),
      .target_valid  (target_valid),
      .target_ready  (target_ready),
      .psen          (psen),
      .psincdec      (psincdec),
      .psdone        (psdone),
      .current_phase (current_phase),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .lock_lost     (lock_lost)
   );

   // PSDONE arrives PsLat cycles after the psen cycle.
   always @(posedge clk) begin
      #1;
      psdone_m = 1'b0;
      if (psen) begin
         ps_cnt = ps_en ? PsLat : 0;
      end else if (ps_cnt > 0) begin
         ps_cnt = ps_cnt - 1;
         if (ps_cnt == 0) psdone_m = 1'b1;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int tgt);
      target_phase = PS_WIDTH'(tgt);
      target_valid = 1'b1;
      tick();
      target_valid = 1'b0;
      target_phase = '0;
   endtask

   task automatic lock_up(input string tag);
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 63) check_eq({tag, "_ready_early"}, int'(target_ready), 0);
         if (i == 64) begin
            check_eq({tag, "_ready"}, int'(target_ready), 1);
            check_eq({tag, "_busy"}, int'(busy), 0);
         end
      end
   endtask

   initial begin
      int psen_n;
      int done_n;

      tick();
      tick();
      check_eq("rst_ready", int'(target_ready), 0);
      check_eq("rst_psen", int'(psen), 0);
      check_eq("rst_psincdec", int'(psincdec), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_terr", int'(timeout_err), 0);
      check_eq("rst_llost", int'(lock_lost), 0);
      check_eq("rst_phase", int'($signed(current_phase)), 0);
      check_eq("rst_busy", int'(busy), 1);
      rst = 1'b0;
      lock_up("lock0");

      // +3 with latency 12
      issue(3);
      check_eq("up_psen0", int'(psen), 1);
      check_eq("up_inc", int'(psincdec), 1);
      check_eq("up_ready_busy", int'(target_ready), 0);
      psen_n = 0;
      done_n = 0;
      for (int k = 1; k <= 39; k++) begin
         tick();
         psen_n += int'(psen);
         done_n += int'(done);
         if (k == 13) check_eq("up_phase1", int'($signed(current_phase)), 1);
         if (k == 26) check_eq("up_phase2", int'($signed(current_phase)), 2);
         if (k == 26) check_eq("up_psen_26", int'(psen), 1);
      end
      check_eq("up_phase3", int'($signed(current_phase)), 3);
      check_eq("up_done39", int'(done), 1);
      check_eq("up_psen_cnt", psen_n, 2);
      check_eq("up_done_cnt", done_n, 1);
      tick();
      check_eq("up_ready_after", int'(target_ready), 1);

      // +3 -> -2
      issue(-2);
      check_eq("dn_dec", int'(psincdec), 0);
      psen_n = 1;
      done_n = 0;
      for (int k = 1; k <= 65; k++) begin
         tick();
         psen_n += int'(psen);
         done_n += int'(done);
         if (k == 64) check_eq("dn_not_done_early", int'(done), 0);
      end
      check_eq("dn_phase", int'($signed(current_phase)), -2);
      check_eq("dn_done65", int'(done), 1);
      check_eq("dn_psen_cnt", psen_n, 5);
      check_eq("dn_done_cnt", done_n, 1);
      tick();

      // target equals position
      issue(-2);
      check_eq("eq_done", int'(done), 1);
      check_eq("eq_psen", int'(psen), 0);
      check_eq("eq_busy", int'(busy), 0);
      tick();
      check_eq("eq_done_clr", int'(done), 0);
      check_eq("eq_ready", int'(target_ready), 1);

      // psdone never returned
      ps_en = 1'b0;
      issue(5);
      check_eq("to_psen", int'(psen), 1);
      for (int k = 1; k <= 1023; k++) begin
         tick();
         if (k == 1022) begin
            check_eq("to_done_early", int'(done), 0);
            check_eq("to_terr_early", int'(timeout_err), 0);
         end
      end
      check_eq("to_done", int'(done), 1);
      check_eq("to_terr", int'(timeout_err), 1);
      check_eq("to_phase", int'($signed(current_phase)), -2);
      ps_en = 1'b1;
      tick();
      check_eq("to_terr_sticky", int'(timeout_err), 1);
      issue(-2);
      check_eq("to_terr_clr", int'(timeout_err), 0);
      tick();

      // +5 steps, lock drops with the 2nd psdone
      issue(3);
      for (int k = 1; k <= 25; k++) tick();
      check_eq("ll_phase_pre", int'($signed(current_phase)), -1);
      check_eq("ll_model_psdone", int'(psdone), 1);
      mmcm_locked = 1'b0;
      tick();
      check_eq("ll_phase", int'($signed(current_phase)), 0);
      check_eq("ll_llost", int'(lock_lost), 1);
      check_eq("ll_done", int'(done), 1);
      check_eq("ll_busy", int'(busy), 1);
      check_eq("ll_ready", int'(target_ready), 0);
      mmcm_locked = 1'b1;
      lock_up("lock1");
      check_eq("ll_sticky", int'(lock_lost), 1);

      // spurious psdone in IDLE
      psdone_f = 1'b1;
      tick();
      psdone_f = 1'b0;
      tick();
      check_eq("sp_phase", int'($signed(current_phase)), 0);
      check_eq("sp_done", int'(done), 0);
      check_eq("sp_psen", int'(psen), 0);
      issue(0);
      check_eq("sp_done_eq", int'(done), 1);
      check_eq("sp_llost_clr", int'(lock_lost), 0);
      tick();

      // reset mid-command aborts without done
      issue(2);
      for (int k = 1; k <= 5; k++) tick();
      rst = 1'b1;
      tick();
      check_eq("ra_done", int'(done), 0);
      check_eq("ra_busy", int'(busy), 1);
      check_eq("ra_psen", int'(psen), 0);
      check_eq("ra_ready", int'(target_ready), 0);
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
